// File: rtl/mag_est_if.sv
// Handshake/result bundle for mag_est_arbiter.
//   enable     arbiter may issue when 1
//   req_i/q    per-requester signed I/Q, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_valid  per-requester sample valid
//   req_ready  per-requester holding buffer empty
//   res_mag    unsigned magnitude estimate
//   res_id     requester owning res_mag
//   res_valid  1-cycle result pulse
//   busy       any buffer full or any sample in flight
// master = sample source / result sink, slave = arbiter.
interface mag_est_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N_REQ      = 4,
  parameter int ID_W       = 2
);
  logic                        enable;
  logic [N_REQ*DATA_WIDTH-1:0] req_i;
  logic [N_REQ*DATA_WIDTH-1:0] req_q;
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]       res_mag;
  logic [ID_W-1:0]             res_id;
  logic                        res_valid;
  logic                        busy;

  modport master (
    output enable, req_i, req_q, req_valid,
    input  req_ready, res_mag, res_id, res_valid, busy
  );

  modport slave (
    input  enable, req_i, req_q, req_valid,
    output req_ready, res_mag, res_id, res_valid, busy
  );
endinterface

// File: rtl/mag_est_arbiter.sv
// mag_est_arbiter: N_REQ I/Q streams share one 3-stage complex_to_mag estimator
// (max(|I|,|Q|) + min(|I|,|Q|)/4). Each requester has a 1-entry holding buffer;
// a round-robin arbiter issues at most one sample per cycle, and a tag pipe
// returns each magnitude with its requester id.
// Ports:
//   clock  clock
//   reset  synchronous, active-high; clears buffers, pointer, tag pipe, estimator
//   bus    mag_est_if.slave (enable, req_*, res_*, busy)

// One requester's holding buffer.
module mag_req_buf #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] i_in,
  input  logic [W-1:0] q_in,
  output logic [W-1:0] i_buf,
  output logic [W-1:0] q_buf,
  output logic         full
);
  // load only when empty and clear only when full, so they never collide
  always_ff @(posedge clock) begin
    if (reset) begin
      full  <= 1'b0;
      i_buf <= '0;
      q_buf <= '0;
    end else begin
      if (clear) full <= 1'b0;
      if (load) begin
        full  <= 1'b1;
        i_buf <= i_in;
        q_buf <= q_in;
      end
    end
  end
endmodule

// 3-cycle magnitude estimator: abs -> max/min -> max + min/4.
module complex_to_mag #(
  parameter int W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                input_strobe,
  input  logic signed [W-1:0] i,
  input  logic signed [W-1:0] q,
  output logic                output_strobe,
  output logic [W-1:0]        mag
);
  logic [W-1:0] abs_i, abs_q, mx, mn;
  logic [3:1]   vld_pipe;

  // two's complement negate in W bits: -2^(W-1) maps to 2^(W-1) unsigned
  function automatic logic [W-1:0] abs_u(input logic [W-1:0] x);
    logic [W-1:0] inv;
    inv = ~x;
    return x[W-1] ? inv + W'(1) : x;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      abs_i    <= '0;
      abs_q    <= '0;
      mx       <= '0;
      mn       <= '0;
      mag      <= '0;
    end else if (enable) begin
      vld_pipe <= {vld_pipe[2:1], input_strobe};
      abs_i    <= abs_u(i);
      abs_q    <= abs_u(q);
      mx       <= (abs_i > abs_q) ? abs_i : abs_q;
      mn       <= (abs_i > abs_q) ? abs_q : abs_i;
      // max <= 2^(W-1), so max + min/4 < 2^W: no overflow
      mag      <= mx + (mn >> 2);
    end
  end

  assign output_strobe = vld_pipe[3];
endmodule

module mag_est_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int N_REQ      = 4,
  parameter int ID_W       = 2
) (
  input logic     clock,
  input logic     reset,
  mag_est_if.slave bus
);
  localparam int W      = DATA_WIDTH;
  localparam int STAGES = 3;

  logic [N_REQ-1:0]        full, load, clear;
  logic [N_REQ-1:0][W-1:0] buf_i, buf_q;
  logic [ID_W-1:0]         ptr, gnt_id;
  logic                    gnt_vld;
  logic [W-1:0]            est_mag;
  logic                    est_strobe;
  logic [STAGES:1]             vld_pipe;
  logic [STAGES:1][ID_W-1:0]   id_pipe;

  assign load          = bus.req_valid & ~full;
  assign bus.req_ready = ~full;

  for (genvar k = 0; k < N_REQ; k++) begin : g_buf
    mag_req_buf #(.W(W)) u_buf (
      .clock (clock),
      .reset (reset),
      .load  (load[k]),
      .clear (clear[k]),
      .i_in  (bus.req_i[k*W +: W]),
      .q_in  (bus.req_q[k*W +: W]),
      .i_buf (buf_i[k]),
      .q_buf (buf_q[k]),
      .full  (full[k])
    );
  end

  // Round-robin: scan offsets from the far end back to 0 so the last hit,
  // which wins, is the full buffer closest at-or-after ptr.
  always_comb begin
    int j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    clear   = '0;
    for (int o = N_REQ - 1; o >= 0; o--) begin
      j = int'(ptr) + o;
      if (j >= N_REQ) j = j - N_REQ;
      if (bus.enable && full[j]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(j);
      end
    end
    if (gnt_vld) clear[gnt_id] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset)
      ptr <= '0;
    else if (gnt_vld)
      ptr <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
  end

  complex_to_mag #(.W(W)) u_est (
    .clock         (clock),
    .reset         (reset),
    .enable        (1'b1),
    .input_strobe  (gnt_vld),
    .i             (buf_i[gnt_id]),
    .q             (buf_q[gnt_id]),
    .output_strobe (est_strobe),
    .mag           (est_mag)
  );

  // tag pipe runs in lockstep with the estimator's valid chain
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], gnt_vld};
      id_pipe  <= {id_pipe[STAGES-1:1], gnt_id};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.res_valid <= 1'b0;
      bus.res_id    <= '0;
      bus.res_mag   <= '0;
    end else begin
      bus.res_valid <= vld_pipe[STAGES];
      if (vld_pipe[STAGES]) begin
        bus.res_id  <= id_pipe[STAGES];
        bus.res_mag <= est_mag;
      end
    end
  end

  assign bus.busy = (|full) | (|vld_pipe);

  a_tag_align: assert property (@(posedge clock) disable iff (reset)
    est_strobe == vld_pipe[STAGES]);
endmodule

// File: tb/tb_mag_est_arbiter.sv
module tb_mag_est_arbiter;
  localparam int W   = 16;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mag_est_if #(.DATA_WIDTH(W), .N_REQ(N), .ID_W(IDW)) bus();

  mag_est_arbiter #(.DATA_WIDTH(W), .N_REQ(N), .ID_W(IDW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct { int due; int id; int mag; } res_t;

  int   n_chk = 0, n_fail = 0, cyc = 0;
  bit   m_full[N];
  logic [W-1:0] m_i[N], m_q[N];
  int   m_ptr;
  res_t exp_q[$];
  bit   last_valid;
  int   last_id, last_mag;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_mag(input logic signed [W-1:0] i, input logic signed [W-1:0] q);
    int a, b;
    a = (i < 0) ? -int'(i) : int'(i);
    b = (q < 0) ? -int'(q) : int'(q);
    return (a > b) ? a + b / 4 : b + a / 4;
  endfunction

  // one clock: advance the reference at the edge, compare at the falling edge
  task automatic step();
    bit old[N];
    int g;
    logic [N-1:0] exp_rdy;
    bit ev, eb;
    @(posedge clock);
    cyc++;
    if (reset) begin
      foreach (m_full[k]) m_full[k] = 1'b0;
      m_ptr = 0;
      exp_q.delete();
    end else begin
      old = m_full;
      g = -1;
      if (bus.enable)
        for (int o = 0; o < N; o++)
          if (g < 0 && old[(m_ptr + o) % N]) g = (m_ptr + o) % N;
      if (g >= 0) begin
        m_full[g] = 1'b0;
        m_ptr = (g + 1) % N;
        exp_q.push_back('{cyc + 3, g, ref_mag(m_i[g], m_q[g])});
      end
      for (int k = 0; k < N; k++)
        if (bus.req_valid[k] && !old[k]) begin
          m_full[k] = 1'b1;
          m_i[k] = bus.req_i[k*W +: W];
          m_q[k] = bus.req_q[k*W +: W];
        end
    end
    @(negedge clock);
    ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    chk("res_valid", bus.res_valid, ev);
    last_valid = bus.res_valid;
    last_id    = int'(bus.res_id);
    last_mag   = int'(bus.res_mag);
    if (ev) begin
      chk("res_id", bus.res_id, exp_q[0].id);
      chk("res_mag", bus.res_mag, exp_q[0].mag);
      void'(exp_q.pop_front());
    end
    eb = 1'b0;
    for (int k = 0; k < N; k++) begin
      exp_rdy[k] = !m_full[k];
      if (m_full[k]) eb = 1'b1;
    end
    foreach (exp_q[e]) if (exp_q[e].due > cyc) eb = 1'b1;
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("busy", bus.busy, eb);
  endtask

  task automatic present(input int k, input int i, input int q);
    bus.req_valid[k]       = 1'b1;
    bus.req_i[k*W +: W]    = W'(i);
    bus.req_q[k*W +: W]    = W'(q);
  endtask

  task automatic idle();
    bus.req_valid = '0;
  endtask

  task automatic wait_res(input string tag, output int lat);
    lat = -1;
    for (int s = 1; s <= 20; s++) begin
      step();
      if (last_valid) begin lat = s; break; end
    end
    if (lat < 0) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic drain();
    for (int s = 0; s < 8; s++) step();
  endtask

  initial begin
    int lat, seen, prev, cnt;
    int ids[8];
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.req_valid = '0;
    bus.req_i = '0;
    bus.req_q = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_mag", bus.res_mag, 0);
    chk("rst_id", bus.res_id, 0);
    chk("rst_ready", bus.req_ready, 4'hF);
    step();

    // single sample, latency from accept edge
    present(0, 3, 4); step(); idle();
    wait_res("t1", lat);
    chk("t1_lat", lat, 4);
    chk("t1_mag", last_mag, 4);
    chk("t1_id", last_id, 0);

    // signs and extremes
    present(1, -100, 40); step(); idle();
    wait_res("t2a", lat);
    chk("t2a_mag", last_mag, 110);
    chk("t2a_id", last_id, 1);
    present(2, -32768, -32768); step(); idle();
    wait_res("t2b", lat);
    chk("t2b_mag", last_mag, 40960);
    chk("t2b_id", last_id, 2);

    // requester 3 alone moves ptr back to 0, then all four loaded together
    present(3, 7, -9); step(); idle();
    wait_res("t3pre", lat);
    drain();
    bus.enable = 1'b0;
    for (int k = 0; k < N; k++) present(k, 100 * (k + 1), -50 * k);
    step(); idle();
    bus.enable = 1'b1;
    seen = 0;
    for (int s = 0; s < 12 && seen < 4; s++) begin
      step();
      if (last_valid) begin ids[seen] = last_id; seen++; end
    end
    chk("t3_count", seen, 4);
    for (int k = 0; k < 4; k++) chk("t3_order", ids[k], k);
    present(3, -1, 1); step(); idle();
    wait_res("t3b", lat);
    chk("t3b_id", last_id, 3);
    drain();

    // fairness: 0 and 2 always valid
    prev = -1; cnt = 0;
    present(0, 1234, -4321); present(2, -20000, 5);
    for (int s = 0; s < 24; s++) begin
      step();
      if (last_valid) begin
        if (prev >= 0) chk("t4_alternate", last_id == prev, 0);
        prev = last_id; cnt++;
      end
    end
    chk("t4_progress", cnt >= 8, 1);
    idle(); drain();

    // enable=0 with 2 in flight and buffer 1 full
    present(0, 500, 600); present(2, -700, 80); step(); idle();
    step(); step();
    bus.enable = 1'b0;
    present(1, 300, -300); step(); idle();
    cnt = 0;
    for (int s = 0; s < 6; s++) begin
      step();
      if (last_valid) cnt++;
    end
    chk("t5_inflight", cnt, 2);
    chk("t5_ready1", bus.req_ready[1], 0);
    bus.enable = 1'b1;
    wait_res("t5b", lat);
    chk("t5b_lat", lat, 4);
    chk("t5b_id", last_id, 1);
    drain();

    // reset one cycle after a grant discards the in-flight sample
    present(0, 9, 9); step(); idle();
    step();
    reset = 1'b1; step(); reset = 1'b0;
    cnt = 0;
    for (int s = 0; s < 5; s++) begin
      step();
      if (last_valid) cnt++;
    end
    chk("t6_novalid", cnt, 0);
    chk("t6_ready", bus.req_ready, 4'hF);
    chk("t6_busy", bus.busy, 0);

    // random traffic against the reference
    for (int s = 0; s < 3000; s++) begin
      bus.enable = ($urandom_range(0, 9) < 8);
      for (int k = 0; k < N; k++) begin
        bus.req_valid[k] = $urandom_range(0, 2) != 0;
        if ($urandom_range(0, 15) == 0)
          bus.req_i[k*W +: W] = 16'h8000;
        else
          bus.req_i[k*W +: W] = W'($urandom);
        bus.req_q[k*W +: W] = W'($urandom);
      end
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0; idle(); drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
